// File: rtl/bist_response_checker_pkg.sv
// Shared constants and state encoding for the BIST response checker.
// Golden values default to the all-zero response of a clean run.
package bist_response_checker_pkg;

    // Controller loop bounds; one run compacts (N+1)*(M+1) words.
    localparam int CTRL_N = 8;
    localparam int CTRL_M = 9;
    localparam int DEF_EXP_CYCLES = (CTRL_N + 1) * (CTRL_M + 1);

    localparam logic [15:0] DEF_POLY   = 16'h100B;
    localparam logic [15:0] DEF_SEED   = 16'h0000;
    localparam logic [15:0] DEF_GOLDEN = 16'h0000;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPACT = 2'd1,
        ST_REPORT  = 2'd2
    } chk_state_t;

endpackage

// File: rtl/bist_response_checker_misr.sv
// Multiple-input signature register: shift left, feed back POLY on MSB, xor in d.
// One-cycle update; load wins over en; no backpressure.
module misr #(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] POLY  = 16'h100B
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            q <= '0;
        end else if (load) begin
            q <= load_val;
        end else if (en) begin
            q <= {q[WIDTH-2:0], 1'b0} ^ (q[WIDTH-1] ? POLY : '0) ^ d;
        end
    end

endmodule

// File: rtl/bist_response_checker.sv
// Compacts CUT responses into a MISR and grades signature/cycle count on FINISH.
// Results registered one cycle after FINISH; no backpressure, strobes always accepted.
module bist_response_checker
    import bist_response_checker_pkg::*;
#(
    parameter int               WIDTH      = 16,
    parameter logic [WIDTH-1:0] POLY       = DEF_POLY,
    parameter logic [WIDTH-1:0] SEED       = DEF_SEED,
    parameter logic [WIDTH-1:0] GOLDEN     = DEF_GOLDEN,
    parameter int               EXP_CYCLES = DEF_EXP_CYCLES
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             INIT,
    input  logic             RUNNING,
    input  logic             FINISH,
    input  logic [WIDTH-1:0] DATA_IN,
    output logic [WIDTH-1:0] SIG,
    output logic [7:0]       CYCLES,
    output logic             DONE,
    output logic             PASS,
    output logic             FAIL,
    output logic             ERR
);

    localparam logic [7:0] EXP_CNT = 8'(EXP_CYCLES);

    chk_state_t state, state_nxt;
    logic [7:0] cycles_nxt;
    logic       done_nxt, pass_nxt, fail_nxt, err_nxt;
    logic       misr_load, misr_en;
    logic       sig_match;

    misr #(
        .WIDTH (WIDTH),
        .POLY  (POLY)
    ) u_misr (
        .CLK      (CLK),
        .RESET    (RESET),
        .load     (misr_load),
        .load_val (SEED),
        .en       (misr_en),
        .d        (DATA_IN),
        .q        (SIG)
    );

    assign sig_match = (SIG == GOLDEN) && (CYCLES == EXP_CNT);

    always_comb begin
        state_nxt  = state;
        cycles_nxt = CYCLES;
        done_nxt   = DONE;
        pass_nxt   = PASS;
        fail_nxt   = FAIL;
        err_nxt    = ERR;
        misr_load  = 1'b0;
        misr_en    = 1'b0;

        if (INIT) begin
            misr_load  = 1'b1;
            cycles_nxt = '0;
            done_nxt   = 1'b0;
            pass_nxt   = 1'b0;
            fail_nxt   = 1'b0;
            err_nxt    = 1'b0;
            state_nxt  = ST_COMPACT;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (FINISH) begin
                        err_nxt   = 1'b1;
                        done_nxt  = 1'b1;
                        fail_nxt  = 1'b1;
                        pass_nxt  = 1'b0;
                        state_nxt = ST_REPORT;
                    end
                end
                ST_COMPACT: begin
                    // FINISH grades the pre-edge signature; that cycle's word is dropped.
                    if (FINISH) begin
                        done_nxt  = 1'b1;
                        pass_nxt  = sig_match;
                        fail_nxt  = !sig_match;
                        state_nxt = ST_REPORT;
                    end else if (RUNNING) begin
                        misr_en    = 1'b1;
                        cycles_nxt = (CYCLES == 8'hFF) ? 8'hFF : CYCLES + 8'd1;
                    end
                end
                ST_REPORT: begin
                    state_nxt = ST_REPORT;
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state  <= ST_IDLE;
            CYCLES <= '0;
            DONE   <= 1'b0;
            PASS   <= 1'b0;
            FAIL   <= 1'b0;
            ERR    <= 1'b0;
        end else begin
            state  <= state_nxt;
            CYCLES <= cycles_nxt;
            DONE   <= done_nxt;
            PASS   <= pass_nxt;
            FAIL   <= fail_nxt;
            ERR    <= err_nxt;
        end
    end

endmodule

// File: tb/tb_bist_response_checker.sv
// Directed plus randomized bench for bist_response_checker against a polynomial-arithmetic model.
// Two instances share stimulus: default golden values, and a short 2-cycle golden of 16'h5B41.
module tb_bist_response_checker;

    localparam logic [15:0] POLY     = 16'h100B;
    localparam logic [15:0] GOLD_B   = 16'h5B41;
    localparam int          EXP_A    = 90;
    localparam int          EXP_B    = 2;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        INIT, RUNNING, FINISH;
    logic [15:0] DATA_IN;

    logic [15:0] sig_a, sig_b;
    logic [7:0]  cyc_a, cyc_b;
    logic        done_a, pass_a, fail_a, err_a;
    logic        done_b, pass_b, fail_b, err_b;

    int total = 0;
    int bad   = 0;

    logic [15:0] m_sig;
    int          m_cnt;

    always #5 CLK = ~CLK;

    bist_response_checker dut_a (
        .CLK(CLK), .RESET(RESET), .INIT(INIT), .RUNNING(RUNNING), .FINISH(FINISH),
        .DATA_IN(DATA_IN), .SIG(sig_a), .CYCLES(cyc_a), .DONE(done_a),
        .PASS(pass_a), .FAIL(fail_a), .ERR(err_a)
    );

    bist_response_checker #(.GOLDEN(GOLD_B), .EXP_CYCLES(EXP_B)) dut_b (
        .CLK(CLK), .RESET(RESET), .INIT(INIT), .RUNNING(RUNNING), .FINISH(FINISH),
        .DATA_IN(DATA_IN), .SIG(sig_b), .CYCLES(cyc_b), .DONE(done_b),
        .PASS(pass_b), .FAIL(fail_b), .ERR(err_b)
    );

    // Signature as polynomial: multiply by x modulo P(x), then add the new word.
    function automatic logic [15:0] model_step(input logic [15:0] s, input logic [15:0] d);
        logic [16:0] t;
        t = {s, 1'b0};
        if (t[16]) t = t ^ {1'b1, POLY};
        return t[15:0] ^ d;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic i, input logic r, input logic f, input logic [15:0] d);
        INIT = i; RUNNING = r; FINISH = f; DATA_IN = d;
        @(posedge CLK);
        #1;
        INIT = 1'b0; RUNNING = 1'b0; FINISH = 1'b0; DATA_IN = $urandom;
    endtask

    task automatic chk_flags_a(input string tag, input logic d, input logic p, input logic f, input logic e);
        chk({tag, ".done_a"}, {15'd0, done_a}, {15'd0, d});
        chk({tag, ".pass_a"}, {15'd0, pass_a}, {15'd0, p});
        chk({tag, ".fail_a"}, {15'd0, fail_a}, {15'd0, f});
        chk({tag, ".err_a"},  {15'd0, err_a},  {15'd0, e});
    endtask

    // One run: INIT, n compaction cycles interleaved with idle gaps, FINISH (with RUNNING high).
    task automatic run(input string tag, input int n, input bit zero_data, input bit gaps);
        logic [15:0] d;
        logic        r;
        logic        pa, pb;
        int          k;
        cyc(1'b1, 1'b0, 1'b0, 16'hFFFF);
        m_sig = 16'h0000;
        m_cnt = 0;
        k = 0;
        while (k < n) begin
            r = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            d = zero_data ? 16'h0000 : 16'($urandom);
            cyc(1'b0, r, 1'b0, d);
            if (r) begin
                m_sig = model_step(m_sig, d);
                m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
                k++;
            end
        end
        chk({tag, ".sig_pre"}, sig_a, m_sig);
        chk({tag, ".cyc_pre"}, {8'd0, cyc_a}, 16'(m_cnt));
        cyc(1'b0, 1'b1, 1'b1, 16'($urandom) | 16'h0001);
        pa = (m_sig == 16'h0000) && (m_cnt == EXP_A);
        pb = (m_sig == GOLD_B)   && (m_cnt == EXP_B);
        chk({tag, ".sig_post"}, sig_a, m_sig);
        chk({tag, ".cyc_post"}, {8'd0, cyc_a}, 16'(m_cnt));
        chk_flags_a(tag, 1'b1, pa, !pa, 1'b0);
        chk({tag, ".pass_b"}, {15'd0, pass_b}, {15'd0, pb});
        chk({tag, ".fail_b"}, {15'd0, fail_b}, {15'd0, !pb});
    endtask

    initial begin
        RESET = 1'b1; INIT = 1'b0; RUNNING = 1'b0; FINISH = 1'b0; DATA_IN = '0;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst.sig", sig_a, 16'h0000);
        chk("rst.cyc", {8'd0, cyc_a}, 16'd0);
        chk_flags_a("rst", 1'b0, 1'b0, 1'b0, 1'b0);
        RESET = 1'b0;
        cyc(1'b0, 1'b1, 1'b0, 16'h1234);
        chk("idle_running_ignored.sig", sig_a, 16'h0000);

        // FINISH with no INIT is a protocol error; further FINISH leaves it alone.
        cyc(1'b0, 1'b0, 1'b1, 16'h0);
        chk_flags_a("proto", 1'b1, 1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 16'h0);
        chk_flags_a("proto_hold", 1'b1, 1'b0, 1'b1, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 16'h0);
        chk_flags_a("proto_clr", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("proto_clr.cyc", {8'd0, cyc_a}, 16'd0);

        run("clean", 90, 1'b1, 1'b0);
        chk("clean.pass_a", {15'd0, pass_a}, 16'd1);
        cyc(1'b0, 1'b1, 1'b1, 16'hBEEF);
        chk("report_hold.pass_a", {15'd0, pass_a}, 16'd1);
        chk("report_hold.cyc", {8'd0, cyc_a}, 16'd90);

        run("short", 89, 1'b1, 1'b0);
        chk("short.fail_a", {15'd0, fail_a}, 16'd1);

        // Two-word signature with an idle gap; FINISH arrives with RUNNING high.
        cyc(1'b1, 1'b0, 1'b0, 16'h0);
        cyc(1'b0, 1'b1, 1'b0, 16'hA5A5);
        cyc(1'b0, 1'b0, 1'b0, 16'h7777);
        cyc(1'b0, 1'b1, 1'b0, 16'h0000);
        chk("arith.sig", sig_b, 16'h5B41);
        cyc(1'b0, 1'b1, 1'b1, 16'hFFFF);
        chk("arith.sig_fin", sig_b, 16'h5B41);
        chk("arith.pass_b", {15'd0, pass_b}, 16'd1);
        chk("arith.fail_a", {15'd0, fail_a}, 16'd1);

        cyc(1'b1, 1'b0, 1'b0, 16'h0);
        cyc(1'b0, 1'b1, 1'b0, 16'hA5A5);
        cyc(1'b0, 1'b1, 1'b0, 16'h0001);
        cyc(1'b0, 1'b0, 1'b1, 16'h0);
        chk("flip.sig", sig_b, 16'h5B40);
        chk("flip.fail_b", {15'd0, fail_b}, 16'd1);

        // INIT and FINISH together: INIT wins, run is live afterwards.
        cyc(1'b1, 1'b0, 1'b1, 16'h0);
        chk("init_fin.done", {15'd0, done_a}, 16'd0);
        cyc(1'b0, 1'b1, 1'b0, 16'h0042);
        chk("init_fin.cyc", {8'd0, cyc_a}, 16'd1);
        chk("init_fin.sig", sig_a, 16'h0042);

        // Restart mid-run discards partial results.
        run("restart", 3, 1'b0, 1'b0);

        // Asynchronous reset mid-run.
        cyc(1'b1, 1'b0, 1'b0, 16'h0);
        for (int i = 0; i < 40; i++) cyc(1'b0, 1'b1, 1'b0, 16'($urandom) | 16'h8000);
        RESET = 1'b1;
        #1;
        chk("midrst.sig", sig_a, 16'h0000);
        chk("midrst.cyc", {8'd0, cyc_a}, 16'd0);
        chk_flags_a("midrst", 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        cyc(1'b0, 1'b1, 1'b0, 16'h5555);
        chk("midrst_wait.sig", sig_a, 16'h0000);
        run("after_rst", 90, 1'b1, 1'b0);
        chk("after_rst.pass_a", {15'd0, pass_a}, 16'd1);

        // Randomized runs, including the counter saturation region.
        for (int t = 0; t < 6; t++) run("rand", $urandom_range(1, 120), 1'b0, 1'b1);
        run("sat", 300, 1'b0, 1'b0);
        chk("sat.cyc", {8'd0, cyc_a}, 16'd255);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
